// File: rtl/uart_trig_pkg.sv
// Shared types and constants for the UART trigger controller: FSM state
// encoding, register addresses and register reset values.
package uart_trig_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL       = 2'd0;
  localparam logic [1:0] ADDR_BAUD       = 2'd1;
  localparam logic [1:0] ADDR_MATCH_MASK = 2'd2;
  localparam logic [1:0] ADDR_POST_CNT   = 2'd3;

  localparam logic [15:0] BAUD_RST       = 16'd434;
  localparam logic [15:0] MATCH_MASK_RST = 16'h0000;
  localparam logic [15:0] POST_CNT_RST   = 16'd0;

endpackage

// File: rtl/uart_trig_ctrl.sv
// UART trigger controller: register file, arm/trigger/post-capture FSM.
// Optional trigger holdoff after arming is enabled by defining TRIG_HOLDOFF_EN.
module uart_trig_ctrl
  import uart_trig_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rd_data,
  input  logic        UARTtrig,
  input  logic        sample_tick,
  output logic [15:0] baud_cnt,
  output logic [7:0]  match,
  output logic [7:0]  mask,
  output logic        capture_en,
  output logic        triggered,
  output logic        done
);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] match_mask_q, match_mask_d;
  logic [15:0] post_cnt_q, post_cnt_d;
  logic        capture_en_q, capture_en_d;
  logic        triggered_q, triggered_d;
  logic        done_q, done_d;

  logic ctrl_wr, arm, abort, cfg_open, holdoff_ok, trig_accept;

  if (HOLDOFF_CYCLES > 32'd65535) begin : g_holdoff_range
    $error("HOLDOFF_CYCLES out of range");
  end

  assign ctrl_wr  = wr_en && (addr == ADDR_CTRL);
  assign arm      = ctrl_wr && wdata[0];
  assign abort    = ctrl_wr && wdata[1];
  assign cfg_open = (state_q == IDLE) || (state_q == DONE);

`ifdef TRIG_HOLDOFF_EN
  localparam int unsigned HW = (HOLDOFF_CYCLES == 0) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(HOLDOFF_CYCLES);

  logic [HW-1:0] holdoff_q, holdoff_d;

  // Holdoff counter: held at zero outside ARMED, saturating count inside.
  always_comb begin
    holdoff_d = holdoff_q;
    if (state_q != ARMED) begin
      holdoff_d = {HW{1'b0}};
    end else if (holdoff_q < HOLD_LIMIT) begin
      holdoff_d = holdoff_q + HW'(1);
    end else begin
      holdoff_d = holdoff_q;
    end
  end

  // Holdoff counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdoff_q <= {HW{1'b0}};
    end else begin
      holdoff_q <= holdoff_d;
    end
  end

  assign holdoff_ok = (holdoff_q >= HOLD_LIMIT);
`else
  assign holdoff_ok = 1'b1;
`endif

  // A trigger sharing a cycle with an arm write is dropped.
  assign trig_accept = (state_q == ARMED) && UARTtrig && !arm && holdoff_ok;

  // FSM next state, post-trigger down-counter, config registers, output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    baud_d       = baud_q;
    match_mask_d = match_mask_q;
    post_cnt_d   = post_cnt_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d = ARMED;
          end else begin
            state_d = state_q;
          end
        end
        ARMED: begin
          if (trig_accept) begin
            state_d = POST;
            cnt_d   = post_cnt_q;
          end else begin
            state_d = ARMED;
          end
        end
        POST: begin
          if (cnt_q == 16'd0) begin
            state_d = DONE;
          end else if (sample_tick) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (wr_en && cfg_open) begin
      case (addr)
        ADDR_BAUD:       baud_d       = wdata;
        ADDR_MATCH_MASK: match_mask_d = wdata;
        ADDR_POST_CNT:   post_cnt_d   = wdata;
        default:         baud_d       = baud_q;
      endcase
    end else begin
      baud_d = baud_q;
    end

    capture_en_d = (state_d == ARMED) || (state_d == POST);
    triggered_d  = (state_d == POST) || (state_d == DONE);
    done_d       = (state_d == DONE);
  end

  // State, counter, configuration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      baud_q       <= BAUD_RST;
      match_mask_q <= MATCH_MASK_RST;
      post_cnt_q   <= POST_CNT_RST;
      capture_en_q <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      baud_q       <= baud_d;
      match_mask_q <= match_mask_d;
      post_cnt_q   <= post_cnt_d;
      capture_en_q <= capture_en_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
    end
  end

  // Combinational register readback.
  always_comb begin
    case (addr)
      ADDR_CTRL:       rd_data = {12'b0, state_q, done_q, capture_en_q};
      ADDR_BAUD:       rd_data = baud_q;
      ADDR_MATCH_MASK: rd_data = match_mask_q;
      ADDR_POST_CNT:   rd_data = post_cnt_q;
      default:         rd_data = 16'd0;
    endcase
  end

  assign baud_cnt   = baud_q;
  assign match      = match_mask_q[15:8];
  assign mask       = match_mask_q[7:0];
  assign capture_en = capture_en_q;
  assign triggered  = triggered_q;
  assign done       = done_q;

endmodule

// File: tb/tb_uart_trig_ctrl.sv
// Self-checking bench for uart_trig_ctrl: directed scenarios then random
// traffic, all checked against a behavioural model of the controller.
module tb_uart_trig_ctrl;
  import uart_trig_pkg::*;

  localparam int unsigned HOLD = 64;
`ifdef TRIG_HOLDOFF_EN
  localparam int unsigned HOLD_EFF = HOLD;
`else
  localparam int unsigned HOLD_EFF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rd_data;
  logic        UARTtrig;
  logic        sample_tick;
  logic [15:0] baud_cnt;
  logic [7:0]  match;
  logic [7:0]  mask;
  logic        capture_en;
  logic        triggered;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  state_t m_st;
  int     m_left;
  int     m_armed_cycles;
  int     m_baud, m_match, m_mask, m_post;

  uart_trig_ctrl #(.HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rd_data(rd_data), .UARTtrig(UARTtrig), .sample_tick(sample_tick),
    .baud_cnt(baud_cnt), .match(match), .mask(mask),
    .capture_en(capture_en), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task model_reset();
    m_st = IDLE; m_left = 0; m_armed_cycles = 0;
    m_baud = 434; m_match = 0; m_mask = 0; m_post = 0;
  endtask

  task model_update(input logic w, input logic [1:0] a, input logic [15:0] d,
                    input logic t, input logic s);
    bit is_arm, is_abort, cfg_ok, hold_ok;
    state_t nxt;
    is_arm   = w && (a == 2'd0) && d[0];
    is_abort = w && (a == 2'd0) && d[1];
    cfg_ok   = (m_st == IDLE) || (m_st == DONE);
    if (w && cfg_ok) begin
      if (a == 2'd1) m_baud = int'(d);
      if (a == 2'd2) begin m_match = int'(d[15:8]); m_mask = int'(d[7:0]); end
      if (a == 2'd3) m_post = int'(d);
    end
    nxt = m_st;
    if (is_abort) nxt = IDLE;
    else if ((m_st == IDLE || m_st == DONE) && is_arm) nxt = ARMED;
    else if (m_st == ARMED) begin
      hold_ok = (m_armed_cycles >= int'(HOLD_EFF));
      if (t && !is_arm && hold_ok) begin nxt = POST; m_left = m_post; end
      m_armed_cycles++;
    end else if (m_st == POST) begin
      if (m_left == 0) nxt = DONE;
      else if (s) m_left--;
    end
    if (nxt == ARMED && m_st != ARMED) m_armed_cycles = 0;
    m_st = nxt;
  endtask

  task check_all();
    logic [15:0] exp_rd;
    logic        e_cap, e_trg, e_done;
    e_cap  = (m_st == ARMED) || (m_st == POST);
    e_trg  = (m_st == POST) || (m_st == DONE);
    e_done = (m_st == DONE);
    case (addr)
      2'd0:    exp_rd = {12'b0, 2'(m_st), e_done, e_cap};
      2'd1:    exp_rd = 16'(m_baud);
      2'd2:    exp_rd = {8'(m_match), 8'(m_mask)};
      default: exp_rd = 16'(m_post);
    endcase
    chk("capture_en", {15'b0, capture_en}, {15'b0, e_cap});
    chk("triggered", {15'b0, triggered}, {15'b0, e_trg});
    chk("done", {15'b0, done}, {15'b0, e_done});
    chk("baud_cnt", baud_cnt, 16'(m_baud));
    chk("match_mask", {match, mask}, {8'(m_match), 8'(m_mask)});
    chk("rd_data", rd_data, exp_rd);
  endtask

  task step(input logic w, input logic [1:0] a, input logic [15:0] d,
            input logic t, input logic s);
    wr_en = w; addr = a; wdata = d; UARTtrig = t; sample_tick = s;
    @(posedge clk);
    model_update(w, a, d, t, s);
    #1;
    wr_en = 1'b0; UARTtrig = 1'b0; sample_tick = 1'b0;
    check_all();
  endtask

  task idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task wr(input logic [1:0] a, input logic [15:0] d);
    step(1'b1, a, d, 1'b0, 1'b0);
  endtask

  task pulse_trig();
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; addr = 2'd0; wdata = 16'd0;
    UARTtrig = 1'b0; sample_tick = 1'b0;
    model_reset();
    #13;
    check_all();
    chk("rst_state", rd_data, 16'h0000);
    rst_n = 1'b1;

    // Config writes discarded while ARMED, accepted after abort
    wr(2'd0, 16'h0001);
    wr(2'd1, 16'd100);
    chk("baud_locked", rd_data, 16'd434);
    wr(2'd0, 16'h0002);
    wr(2'd1, 16'd100);
    chk("baud_after_abort", rd_data, 16'd100);

    // Full capture with POST_CNT=4
    wr(2'd1, 16'd868);
    wr(2'd2, 16'hA500);
    wr(2'd3, 16'd4);
    wr(2'd0, 16'h0001);
    idle(HOLD_EFF);
    pulse_trig();
    chk("trig_accepted", {15'b0, triggered}, 16'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
    chk("not_done_at_tick4", {15'b0, done}, 16'd0);
    idle(1);
    chk("done_after_4", {15'b0, done}, 16'd1);
    chk("cap_off_done", {15'b0, capture_en}, 16'd0);
    chk("baud_868", baud_cnt, 16'd868);
    chk("match_a5", {8'b0, match}, 16'h00A5);
    chk("mask_0", {8'b0, mask}, 16'h0000);

    // POST_CNT=0: one POST cycle then DONE without ticks
    wr(2'd3, 16'd0);
    wr(2'd0, 16'h0001);
    idle(HOLD_EFF);
    pulse_trig();
    chk("post0_state", {14'b0, rd_data[3:2]}, {14'b0, POST});
    idle(1);
    chk("post0_done", {15'b0, done}, 16'd1);

    // Arm + abort together in DONE
    wr(2'd0, 16'h0003);
    chk("arm_abort_idle", rd_data, 16'h0000);

    // Holdoff window
    wr(2'd0, 16'h0001);
    idle(10);
    pulse_trig();
    chk("trig_cycle10", {15'b0, triggered}, (HOLD_EFF > 10) ? 16'd0 : 16'd1);
    idle(59);
    pulse_trig();
    chk("trig_cycle70", {15'b0, triggered}, 16'd1);
    wr(2'd0, 16'h0002);

    // Reset mid-capture with counter at 3
    wr(2'd3, 16'd4);
    wr(2'd0, 16'h0001);
    idle(HOLD_EFF);
    pulse_trig();
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check_all();
    end
    addr = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
    wr(2'd3, 16'd2);
    wr(2'd0, 16'h0001);
    idle(HOLD_EFF);
    pulse_trig();
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
    idle(1);
    chk("fresh_run_done", {15'b0, done}, 16'd1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        w, t, s;
      logic [1:0]  a;
      logic [15:0] d;
      w = ($urandom_range(3) == 0);
      a = 2'($urandom_range(3));
      d = 16'($urandom);
      if (a == 2'd0) begin
        d[0] = ($urandom_range(1) == 1);
        d[1] = ($urandom_range(9) == 0);
      end else if (a == 2'd3) begin
        d = 16'($urandom_range(7));
      end
      t = ($urandom_range(7) == 0);
      s = ($urandom_range(1) == 1);
      step(w, a, d, t, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
